// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Unsigned M-bit dividend by N-bit divisor with a start/busy/done handshake.
// The operands are captured on the accepted start. A zero divisor is flagged
// after one cycle, and the block never enters RUN for it.
module seq_divider #(
    parameter int M = 26,
    parameter int N = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    // Dividend shift register. Dividend bits leave at the MSB, and quotient
    // bits enter at the LSB. After M shifts it holds the quotient.
    logic [M-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    // Partial remainder. It is always below the divisor, so the extra top
    // bit of the (N+1)-bit trial value never needs to be stored.
    logic [N-1:0]   part_q, part_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           done_q, done_d;
    // Set one cycle after a zero-divisor start; it produces the flagged done.
    logic           pend_q, pend_d;

    logic [N:0]     trial;
    logic           ge;
    logic [N-1:0]   part_new;

    // Restoring step: bring in the next dividend bit, then subtract if it fits.
    always_comb begin
        trial    = {part_q, dvd_q[M-1]};
        ge       = (trial >= {1'b0, dvs_q});
        part_new = ge ? N'(trial - {1'b0, dvs_q}) : N'(trial);
    end

    // Next-state logic: handshake, iteration control and result registering.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        pend_d  = 1'b0;

        if (pend_q) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quot_d = '1;
            rem_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        part_d  = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                part_d = part_new;
                dvd_d  = {dvd_q[M-2:0], ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) begin
                    quot_d  = {dvd_q[M-2:0], ge};
                    rem_d   = part_new;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: a vector table plus hand-written multi-cycle sequences.
module tb_seq_divider;

    localparam int M = 26;
    localparam int N = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [M-1:0] a;
        logic [N-1:0] b;
        logic [M-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    seq_divider #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Count any done pulses over a window in which none is expected.
    task automatic no_done_window(input string name, input int n);
        int extra;
        extra = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check(name, extra, 0);
    endtask

    // One division with a single start pulse; operands are scrambled right after capture.
    task automatic run_div(input vec_t v, input string tag);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~v.a;
        divisor  = ~v.b;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (busy !== (v.z ? 1'b0 : 1'b1)) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, v.lat);
        check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'(v.q));
        check({tag, "_remainder"}, 32'(remainder), 32'(v.r));
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, v.z});
        @(posedge clk); #1;
        check({tag, "_done_single"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [M-1:0] ra[3];
        logic [N-1:0] rb[3];

        vecs[0] = '{a: 26'd50000000, b: 14'd10000, q: 26'd5000,     r: 14'd0,    z: 1'b0, lat: 26};
        vecs[1] = '{a: 26'd67108863, b: 14'd16383, q: 26'd4096,     r: 14'd4095, z: 1'b0, lat: 26};
        vecs[2] = '{a: 26'd67108863, b: 14'd1,     q: 26'd67108863, r: 14'd0,    z: 1'b0, lat: 26};
        vecs[3] = '{a: 26'd1000,     b: 14'd16383, q: 26'd0,        r: 14'd1000, z: 1'b0, lat: 26};
        vecs[4] = '{a: 26'd12345,    b: 14'd0,     q: 26'h3FFFFFF,  r: 14'd0,    z: 1'b1, lat: 1};
        vecs[5] = '{a: 26'd7,        b: 14'd3,     q: 26'd2,        r: 14'd1,    z: 1'b0, lat: 26};
        vecs[6] = '{a: 26'd100,      b: 14'd7,     q: 26'd14,       r: 14'd2,    z: 1'b0, lat: 26};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i], $sformatf("vec%0d", i));
            $display("vec%0d: %0d / %0d -> q=%0d r=%0d dbz=%0d", i, vecs[i].a, vecs[i].b,
                     quotient, remainder, div_by_zero);
        end

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        dividend = 26'd50000000;
        divisor  = 14'd10000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        $display("async reset mid-run: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(vecs[6], "post_reset");
        no_done_window("post_reset_no_extra_done", 30);
        $display("post-reset 100/7 -> q=%0d r=%0d", quotient, remainder);

        // Start pulses and operand changes while RUN are ignored.
        @(negedge clk);
        dividend = 26'd1000;
        divisor  = 14'd16383;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc == 5)  begin start = 1'b1; dividend = 26'd999999; divisor = 14'd3; end
            if (cyc == 6)  start = 1'b0;
            if (cyc == 10) begin start = 1'b1; divisor = 14'd0; end
            if (cyc == 11) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("midrun_latency", cyc, 26);
        check("midrun_quotient", 32'(quotient), 32'd0);
        check("midrun_remainder", 32'(remainder), 32'd1000);
        check("midrun_dbz", {31'd0, div_by_zero}, 32'd0);
        no_done_window("midrun_no_extra_done", 40);
        $display("mid-run start ignored: q=%0d r=%0d", quotient, remainder);

        // Back-to-back divisions with start held high.
        for (int i = 0; i < 3; i++) begin
            ra[i] = M'($urandom_range(32'h3FFFFFF, 0));
            rb[i] = N'($urandom_range(16383, 1));
        end
        @(negedge clk);
        dividend = ra[0];
        divisor  = rb[0];
        start    = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!done && cyc < 100);
            check($sformatf("b2b%0d_interval", i), cyc, (i == 0) ? 26 : 27);
            check($sformatf("b2b%0d_quotient", i), 32'(quotient), 32'(ra[i]) / 32'(rb[i]));
            check($sformatf("b2b%0d_remainder", i), 32'(remainder), 32'(ra[i]) % 32'(rb[i]));
            $display("b2b%0d: %0d / %0d -> q=%0d r=%0d interval=%0d", i, ra[i], rb[i],
                     quotient, remainder, cyc);
            if (i < 2) begin
                dividend = ra[i+1];
                divisor  = rb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        no_done_window("b2b_no_extra_done", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
